axis_wrr_scheduler: RTL and testbench

- Weighted round-robin frame scheduler that decides which AXI-stream input owns a shared output path.
- Drives the select of an S_COUNT:1 stream mux, such as the per-output mux inside the stream switch.
- Watches the muxed output handshake and holds each grant for exactly one frame, ending at tlast.
- Each port may send up to its weight in frames per round; a new round reloads all credits.

---
 rtl/axis_wrr_scheduler.sv | 118 +++++++++++
 tb/tb_axis_wrr_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_wrr_scheduler.sv
// axis_wrr_scheduler: weighted round-robin frame scheduler driving an S_COUNT:1 stream mux select.
// Optional stall release compiled in with AXIS_WRR_SCHEDULER_TIMEOUT_EN.
module axis_wrr_scheduler #(
  parameter int PORTS          = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                          beat_valid,
  input  logic                          beat_ready,
  input  logic                          beat_last,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          round_start,
  output logic                          timeout
);
  localparam int IW = $clog2(PORTS);
  localparam logic [1:0] IDLE = 2'd0, RELOAD = 2'd1, GRANT = 2'd2;
  localparam logic [PORTS-1:0] ONE = 1;
  logic [1:0] state;
  logic [WEIGHT_WIDTH-1:0] credit [PORTS];
  logic [IW-1:0] ptr, g_inc;
  logic [PORTS-1:0] elig, elig_w;
  logic [IW:0] sel_c, sel_w;
  logic [WEIGHT_WIDTH-1:0] cg;
  logic fire, to;

  // first set bit of e searching upward from p with wrap; MSB flags a hit
  function automatic logic [IW:0] pick(input logic [PORTS-1:0] e, input logic [IW-1:0] p);
    logic [IW:0] r;
    r = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      int j;
      j = (int'(p) + k) % PORTS;
      if (e[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    elig = '0;
    elig_w = '0;
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = request[i] && credit[i] != '0;
      elig_w[i] = request[i] && weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0;
    end
  end

  assign sel_c = pick(elig, ptr);
  assign sel_w = pick(elig_w, ptr);
  assign cg    = credit[grant_encoded];
  assign fire  = beat_valid && beat_ready && beat_last;
  assign g_inc = grant_encoded == IW'(PORTS - 1) ? '0 : grant_encoded + 1'b1;

`ifdef AXIS_WRR_SCHEDULER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic stall;
  assign stall = !(beat_valid && beat_ready);
  assign to = state == GRANT && stall && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == GRANT && stall && !to) ? cnt + 1'b1 : '0;
`else
  assign to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      grant_valid <= 1'b0;
      grant_encoded <= '0;
      round_start <= 1'b0;
      timeout <= 1'b0;
      for (int i = 0; i < PORTS; i++) credit[i] <= '0;
    end else begin
      round_start <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE:
          if (sel_c[IW]) begin
            grant <= ONE << sel_c[IW-1:0];
            grant_encoded <= sel_c[IW-1:0];
            grant_valid <= 1'b1;
            state <= GRANT;
          end else if (|elig_w) begin
            round_start <= 1'b1;
            state <= RELOAD;
          end
        RELOAD: begin
          for (int i = 0; i < PORTS; i++) credit[i] <= weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          if (sel_w[IW]) begin
            grant <= ONE << sel_w[IW-1:0];
            grant_encoded <= sel_w[IW-1:0];
            grant_valid <= 1'b1;
            state <= GRANT;
          end else state <= IDLE;
        end
        GRANT:
          if (fire || to) begin
            if (cg != '0) credit[grant_encoded] <= cg - 1'b1;
            ptr <= (cg > 1 && !to) ? grant_encoded : g_inc;
            grant <= '0;
            grant_valid <= 1'b0;
            timeout <= to;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_wrr_scheduler.sv
// tb_axis_wrr_scheduler: directed checks of the weighted round-robin scheduler.
module tb_axis_wrr_scheduler;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] request = '0;
  logic [15:0] weight = '0;
  logic beat_valid = 1'b0, beat_ready = 1'b1, beat_last = 1'b1;
  logic [3:0] grant;
  logic grant_valid, round_start, timeout;
  logic [1:0] grant_encoded;
  int total = 0, bad = 0;

  axis_wrr_scheduler #(.PORTS(4), .WEIGHT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .request(request), .weight(weight),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_last(beat_last),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .round_start(round_start), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] req, input logic [15:0] w, input logic bv);
    rst = 1'b1;
    request = req;
    weight = w;
    beat_valid = bv;
    beat_ready = 1'b1;
    beat_last = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({grant, grant_valid, grant_encoded, round_start, timeout} !== 9'b0) begin
      bad++;
      $display("FAIL reset: got grant=%b gv=%b enc=%0d rs=%b to=%b, want all 0", grant, grant_valid, grant_encoded, round_start, timeout);
    end
    start(4'b1111, 16'h3201, 1'b1);
  endtask

  task automatic test_round;
    logic [4:0] exp_r [13] = '{5'h10, 5'h01, 5'h00, 5'h04, 5'h00, 5'h04, 5'h00, 5'h08, 5'h00, 5'h08, 5'h00, 5'h08, 5'h00};
    for (int c = 0; c < 26; c++) begin
      tick();
      total++;
      if ({round_start, grant} !== exp_r[c % 13] || grant_valid !== |exp_r[c % 13][3:0]) begin
        bad++;
        $display("FAIL round cyc%0d: got rs=%b grant=%b gv=%b, want rs=%b grant=%b", c, round_start, grant, grant_valid, exp_r[c % 13][4], exp_r[c % 13][3:0]);
      end
    end
  endtask

  task automatic test_disabled;
    start(4'b0010, 16'h3201, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (grant_valid !== 1'b0 || round_start !== 1'b0 || grant !== 4'b0) begin
        bad++;
        $display("FAIL disabled cyc%0d: got gv=%b rs=%b grant=%b, want 0 0 0000", c, grant_valid, round_start, grant);
      end
    end
  endtask

  task automatic test_frame_hold;
    logic br_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic bl_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start(4'b0100, 16'h3201, 1'b0);
    tick();
    tick();
    total++;
    if (grant !== 4'b0100 || grant_encoded !== 2'd2) begin
      bad++;
      $display("FAIL hold_grant: got grant=%b enc=%0d, want 0100 2", grant, grant_encoded);
    end
    beat_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      beat_ready = br_seq[b];
      beat_last = bl_seq[b];
      tick();
      if (b == 0) request = 4'b0000;
      total++;
      if (b < 4 && (grant !== 4'b0100 || grant_valid !== 1'b1)) begin
        bad++;
        $display("FAIL hold_beat%0d: got grant=%b gv=%b, want 0100 1", b, grant, grant_valid);
      end else if (b == 4 && (grant !== 4'b0 || grant_valid !== 1'b0)) begin
        bad++;
        $display("FAIL hold_release: got grant=%b gv=%b, want 0000 0", grant, grant_valid);
      end
    end
    beat_valid = 1'b0;
    beat_last = 1'b1;
    request = 4'b0100;
    tick();
    total++;
    if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_regrant: got grant=%b gv=%b, want 0100 1", grant, grant_valid);
    end
  endtask

  task automatic test_weight_change;
    int exp_w [16] = '{0, 2, 2, 3, 3, 3, 0, 0, 0, 0, 0, 2, 2, 3, 3, 3};
    int got [16];
    int n = 0;
    start(4'b1111, 16'h3201, 1'b1);
    for (int c = 0; c < 35; c++) begin
      tick();
      if (grant_valid === 1'b1 && n < 16) begin
        got[n] = int'(grant_encoded);
        n++;
        if (n == 1) weight = 16'h3205;
      end
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL wchg_count: got %0d grants, want 16", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i] != exp_w[i]) begin
        bad++;
        $display("FAIL wchg_grant%0d: got port %0d, want port %0d", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    start(4'b1000, 16'h3201, 1'b0);
    tick();
    tick();
    total++;
    if (grant !== 4'b1000 || grant_encoded !== 2'd3) begin
      bad++;
      $display("FAIL rmf_grant: got grant=%b enc=%0d, want 1000 3", grant, grant_encoded);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_encoded !== 2'd0) begin
      bad++;
      $display("FAIL rmf_async: got grant=%b gv=%b enc=%0d, want 0000 0 0", grant, grant_valid, grant_encoded);
    end
    request = 4'b1100;
    #1 rst = 1'b0;
    tick();
    total++;
    if (round_start !== 1'b1 || grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmf_reload: got rs=%b gv=%b, want 1 0", round_start, grant_valid);
    end
    tick();
    total++;
    if (grant !== 4'b0100 || grant_encoded !== 2'd2) begin
      bad++;
      $display("FAIL rmf_regrant: got grant=%b enc=%0d, want 0100 2", grant, grant_encoded);
    end
  endtask

`ifdef AXIS_WRR_SCHEDULER_TIMEOUT_EN
  task automatic test_timeout;
    start(4'b0011, 16'h3211, 1'b0);
    tick();
    tick();
    for (int c = 1; c <= 9; c++) begin
      tick();
      total++;
      if (c < 8 && (grant !== 4'b0001 || timeout !== 1'b0)) begin
        bad++;
        $display("FAIL to_hold%0d: got grant=%b to=%b, want 0001 0", c, grant, timeout);
      end else if (c == 8 && (timeout !== 1'b1 || grant_valid !== 1'b0)) begin
        bad++;
        $display("FAIL to_pulse: got to=%b gv=%b, want 1 0", timeout, grant_valid);
      end else if (c == 9 && (timeout !== 1'b0 || grant !== 4'b0010)) begin
        bad++;
        $display("FAIL to_next: got to=%b grant=%b, want 0 0010", timeout, grant);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round();
    test_disabled();
    test_frame_hold();
    test_weight_change();
    test_reset_mid_frame();
`ifdef AXIS_WRR_SCHEDULER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
